hp35_wb_sram_loader: RTL and testbench
======================================

Name: hp35_wb_sram_loader

Overview:
- Wishbone classic responder to the management SoC initiator.
- Drives port 0 (RW) of the 32x256 program SRAM, so microcode is loaded and verified over Wishbone instead of bit-banged LA writes.
- Exposes one control/status register holding the HP-35 core in hold and counting completed writes.
- Sits in user_project_wrapper between the wbs_* pins and the SRAM port-0 pins. Port 1 stays owned by hp35_core.

Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone base of the block; decode on wbs_adr_i[31:12].
- SRAM_AW, 8: SRAM word-address width; window is 2**SRAM_AW words.
- CTRL_OFS, 12'h400: byte offset of the control/status register.

Ports:
- wb_clk_i  in  1  Wishbone/system clock; also drives sram_clk0 externally
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- sram_csb0  out  1  port-0 chip select, active low
- sram_web0  out  1  port-0 write enable, active low
- sram_wmask0  out  4  port-0 byte mask
- sram_addr0  out  SRAM_AW  port-0 word address
- sram_din0  out  32  port-0 write data
- sram_dout0  in  32  port-0 read data
- core_hold  out  1  holds hp35_core in cdiv reset while loading

Behaviour:
- All outputs are registered. Reset values:
  - wbs_ack_o=0, wbs_dat_o=0
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0
  - core_hold=1, write counter=0, FSM=IDLE
- Hit condition: cyc & stb & (adr[31:12]==BASE_ADDR[31:12]).
  - SRAM window: adr[11:10]==0; word address = adr[SRAM_AW+1:2].
  - CTRL: adr[11:0]==CTRL_OFS.
  - Other offsets inside the block: MISS.
- FSM states: IDLE, SR_ISSUE, SR_WAIT, SR_CAP, ACK.
  - IDLE, SRAM hit at edge N: load addr/din/wmask (=sel on write, 4'b0000 on read), drive csb0=0 and web0=~we; go to SR_ISSUE.
  - SR_ISSUE: SRAM samples inputs at edge N+1; csb0/web0 return to 1; go to SR_WAIT.
  - SR_WAIT: dout settles; go to SR_CAP.
  - SR_CAP: on a read, capture sram_dout0 into wbs_dat_o; on a write, increment the counter; assert ack; go to ACK.
  - ACK: ack is high for exactly this one cycle (cycle N+4 relative to acceptance). Deassert ack and return to IDLE.
  - IDLE, CTRL or MISS hit: ack high in cycle N+1 via ACK, with no SRAM activity.
- CTRL register:
  - bit0 core_hold, RW, reset 1.
  - bits[15:1] read as 0.
  - bits[31:16] write_count, RO, 16-bit, wraps 16'hFFFF -> 0.
  - A CTRL write honours sel[0] only.
- MISS: writes are ignored; reads return 32'h0; ack is still given (no ERR line).
- Back-to-back: if stb stays high after ack, a new access is accepted in the cycle after ACK (IDLE). There is no pipelined mode.
- wbs_dat_o holds its last value between reads and is only updated on read completion.
- cyc drops mid-SRAM access: the issued SRAM op still completes (writes are committed and counted); ack is suppressed; FSM returns to IDLE.
- Reset mid-operation: immediate return to reset values. An SRAM write already sampled may or may not be committed; the bench must not check it.

Optional Feature:
- Macro: HP35_WB_LA_OVERRIDE_EN.
- When defined, extra ports are added: la_sel (in 1), la_csb0, la_web0, la_clk_gate (in 1 each), la_addr0 (in SRAM_AW), la_din0 (in 30).
  - la_sel=1 muxes the LA signals onto the SRAM port-0 outputs, with wmask=4'b1111 and din upper 2 bits = 0.
  - While la_sel=1, Wishbone SRAM accesses return data 0 and ack normally without touching the SRAM; CTRL is unaffected.
- When undefined, none of these ports exist and Wishbone is the sole owner of port 0.

Decomposition:
- Package hp35_wb_pkg holds:
  - FSM state enum
  - CTRL_OFS and bit positions (HOLD_BIT=0, WCNT_LSB=16)
  - SRAM window size
  - SRAM_LAT=3 (issue-to-capture)
- One natural sub-module, hp35_port0_mux: the registered/LA port-0 selector. It is only instantiated when HP35_WB_LA_OVERRIDE_EN is defined.

Test Plan:
- Reset release -> read 0x3000_0400 returns 32'h0000_0001; ack exactly 1 cycle at N+1; csb0 held 1 throughout.
- Write 0xDEAD_BEEF, sel=4'hF, to 0x3000_0010 -> csb0=0, web0=0, addr0=4, din0=DEADBEEF for one cycle; ack at N+4. Then read 0x3000_0010 -> 0xDEADBEEF; CTRL[31:16]=1.
- Write 0x1122_3344 with sel=4'b0101 over prior 0xFFFF_FFFF at word 255 (0x3000_03FC) -> wmask0=4'b0101; readback 0xFF22_FF44.
- Write CTRL 0x0 -> core_hold=0 at N+1. Read 0x3000_0800 (miss) -> data 0, ack, no SRAM strobe.
- Drop cyc at cycle N+2 of a write to word 7 -> no ack; CTRL write count still increments; subsequent read of word 7 returns the written data.
- Issue 65536 writes -> CTRL[31:16] wraps to 0x0000.

Source files
------------

// File: rtl/hp35_wb_pkg.sv
// hp35_wb_pkg: shared FSM encoding, register layout and SRAM geometry for the
// HP-35 Wishbone program-SRAM loader.
package hp35_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SR_ISSUE = 3'd1,
    ST_SR_WAIT  = 3'd2,
    ST_SR_CAP   = 3'd3,
    ST_ACK      = 3'd4
  } state_e;

  localparam logic [11:0] CTRL_OFS_DEFAULT = 12'h400;
  localparam int          HOLD_BIT         = 0;
  localparam int          WCNT_LSB         = 16;
  localparam int          WCNT_W           = 16;

  localparam int          SRAM_WORDS       = 256;
  // Edges from SRAM strobe issue to read-data capture.
  localparam int          SRAM_LAT         = 3;

endpackage

// File: rtl/hp35_port0_mux.sv
// hp35_port0_mux: registered selector between the Wishbone engine and the LA
// pins for SRAM port 0. Only present when HP35_WB_LA_OVERRIDE_EN is defined.
`ifdef HP35_WB_LA_OVERRIDE_EN
module hp35_port0_mux #(
  parameter int unsigned SRAM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               la_sel,
  input  logic               la_csb0,
  input  logic               la_web0,
  input  logic               la_clk_gate,
  input  logic [SRAM_AW-1:0] la_addr0,
  input  logic [29:0]        la_din0,
  input  logic               wb_csb,
  input  logic               wb_web,
  input  logic [3:0]         wb_wmask,
  input  logic [SRAM_AW-1:0] wb_addr,
  input  logic [31:0]        wb_din,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [3:0]         sram_wmask0,
  output logic [SRAM_AW-1:0] sram_addr0,
  output logic [31:0]        sram_din0
);

  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        din_q, din_d;

  // A low la_clk_gate keeps the SRAM deselected while the LA owns the port.
  always_comb begin
    csb_d   = wb_csb;
    web_d   = wb_web;
    wmask_d = wb_wmask;
    addr_d  = wb_addr;
    din_d   = wb_din;
    if (la_sel) begin
      csb_d   = la_csb0 | ~la_clk_gate;
      web_d   = la_web0;
      wmask_d = 4'b1111;
      addr_d  = la_addr0;
      din_d   = {2'b00, la_din0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

endmodule
`endif

// File: rtl/hp35_wb_sram_loader.sv
// hp35_wb_sram_loader: Wishbone classic responder that loads/verifies the HP-35
// program SRAM through port 0 and owns the core_hold CTRL register.
// Optional LA override of port 0: define HP35_WB_LA_OVERRIDE_EN.
module hp35_wb_sram_loader
  import hp35_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned SRAM_AW   = 8,
  parameter logic [11:0] CTRL_OFS  = CTRL_OFS_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [3:0]         sram_wmask0,
  output logic [SRAM_AW-1:0] sram_addr0,
  output logic [31:0]        sram_din0,
  input  logic [31:0]        sram_dout0,
  output logic               core_hold
`ifdef HP35_WB_LA_OVERRIDE_EN
  ,
  input  logic               la_sel,
  input  logic               la_csb0,
  input  logic               la_web0,
  input  logic               la_clk_gate,
  input  logic [SRAM_AW-1:0] la_addr0,
  input  logic [29:0]        la_din0
`endif
);

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [3:0]           wmask_q, wmask_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]          din_q, din_d;
  logic                 csb_d, web_d;
  logic                 hold_q, hold_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic                 we_q, we_d;
  logic                 abort_q, abort_d;

  logic                 hit, sram_hit, ctrl_hit, sram_go;
  logic [31:0]          ctrl_word;

  always_comb begin
    hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    sram_hit = hit & (wbs_adr_i[11:10] == 2'b00);
    ctrl_hit = hit & (wbs_adr_i[11:0] == CTRL_OFS);
`ifdef HP35_WB_LA_OVERRIDE_EN
    sram_go  = sram_hit & ~la_sel;
`else
    sram_go  = sram_hit;
`endif
    ctrl_word                       = '0;
    ctrl_word[HOLD_BIT]             = hold_q;
    ctrl_word[WCNT_LSB +: WCNT_W]   = wcnt_q;
  end

  // abort_q remembers a dropped cyc anywhere in the SRAM sequence so a new
  // cycle raised before capture is never acked for the old access.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    hold_d  = hold_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    abort_d = abort_q;

    case (state_q)
      ST_IDLE: begin
        if (sram_go) begin
          addr_d  = wbs_adr_i[SRAM_AW+1:2];
          din_d   = wbs_dat_i;
          wmask_d = wbs_we_i ? wbs_sel_i : 4'b0000;
          csb_d   = 1'b0;
          web_d   = ~wbs_we_i;
          we_d    = wbs_we_i;
          abort_d = 1'b0;
          state_d = ST_SR_ISSUE;
        end else if (hit) begin
          ack_d   = 1'b1;
          state_d = ST_ACK;
          if (ctrl_hit) begin
            if (wbs_we_i) begin
              if (wbs_sel_i[0]) hold_d = wbs_dat_i[HOLD_BIT];
            end else begin
              dat_d = ctrl_word;
            end
          end else if (!wbs_we_i) begin
            dat_d = '0;
          end
        end
      end
      ST_SR_ISSUE: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        state_d = ST_SR_WAIT;
      end
      ST_SR_WAIT: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        state_d = ST_SR_CAP;
      end
      ST_SR_CAP: begin
        if (we_q) wcnt_d = wcnt_q + 16'd1;
        if (abort_q || !wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          ack_d   = 1'b1;
          state_d = ST_ACK;
          if (!we_q) dat_d = sram_dout0;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      hold_q  <= 1'b1;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      hold_q  <= hold_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      abort_q <= abort_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign core_hold = hold_q;

`ifdef HP35_WB_LA_OVERRIDE_EN
  hp35_port0_mux #(
    .SRAM_AW (SRAM_AW)
  ) u_port0_mux (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .la_sel      (la_sel),
    .la_csb0     (la_csb0),
    .la_web0     (la_web0),
    .la_clk_gate (la_clk_gate),
    .la_addr0    (la_addr0),
    .la_din0     (la_din0),
    .wb_csb      (csb_d),
    .wb_web      (web_d),
    .wb_wmask    (wmask_d),
    .wb_addr     (addr_d),
    .wb_din      (din_d),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0)
  );
`else
  logic csb_q, web_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      csb_q <= 1'b1;
      web_q <= 1'b1;
    end else begin
      csb_q <= csb_d;
      web_q <= web_d;
    end
  end

  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
`endif

endmodule

// File: tb/tb_hp35_wb_sram_loader.sv
// tb_hp35_wb_sram_loader: directed Wishbone bench for the HP-35 SRAM loader,
// with a behavioural 32x256 port-0 SRAM model.
module tb_hp35_wb_sram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
  logic        core_hold;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem [0:255];

  int          strobes;
  logic [7:0]  sAddr;
  logic [31:0] sDin;
  logic        sWeb;
  logic [3:0]  sWmask;
  logic        holdAtAck;
  logic        ackAfter;

  always #5 clk = ~clk;

  hp35_wb_sram_loader dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0),
    .core_hold   (core_hold)
  );

  // Port-0 SRAM model: samples on the rising edge, byte-masked writes.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] = sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One classic Wishbone access; lat is the negedge index of ack after the
  // accepting edge (1 = cycle N+1), or -1 if no ack within budget.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int budget,
                               output logic [31:0] rdat, output int lat);
    lat     = -1;
    rdat    = '0;
    strobes = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int j = 1; j <= budget && lat < 0; j++) begin
      @(negedge clk);
      if (!sram_csb0) begin
        strobes++;
        sAddr  = sram_addr0;
        sDin   = sram_din0;
        sWeb   = sram_web0;
        sWmask = sram_wmask0;
      end
      if (wbs_ack_o) begin
        lat       = j;
        rdat      = wbs_dat_o;
        holdAtAck = core_hold;
      end
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    ackAfter = wbs_ack_o;
    if (!sram_csb0) strobes++;
  endtask

  logic [31:0] rd;
  int          lat;
  int          ackCount, firstAck, secondAck;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    sram_dout0 = '0;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);

    checkOutput("rstAck",   32'(wbs_ack_o),   32'd0);
    checkOutput("rstDat",   wbs_dat_o,        32'd0);
    checkOutput("rstCsb",   32'(sram_csb0),   32'd1);
    checkOutput("rstWeb",   32'(sram_web0),   32'd1);
    checkOutput("rstWmask", 32'(sram_wmask0), 32'd0);
    checkOutput("rstAddr",  32'(sram_addr0),  32'd0);
    checkOutput("rstDin",   sram_din0,        32'd0);
    checkOutput("rstHold",  32'(core_hold),   32'd1);
    rst_n = 1'b1;

    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("ctrlRstRead", rd, 32'h0000_0001);
    checkOutput("ctrlLat", lat, 32'd1);
    checkOutput("ctrlAckOneCycle", 32'(ackAfter), 32'd0);
    checkOutput("ctrlNoStrobe", strobes, 32'd0);

    applyStimulus(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 8, rd, lat);
    checkOutput("wrLat", lat, 32'd4);
    checkOutput("wrStrobes", strobes, 32'd1);
    checkOutput("wrAddr", 32'(sAddr), 32'd4);
    checkOutput("wrDin", sDin, 32'hDEAD_BEEF);
    checkOutput("wrWeb", 32'(sWeb), 32'd0);
    checkOutput("wrWmask", 32'(sWmask), 32'hF);
    checkOutput("wrAckOneCycle", 32'(ackAfter), 32'd0);

    applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("rdData", rd, 32'hDEAD_BEEF);
    checkOutput("rdLat", lat, 32'd4);
    checkOutput("rdWeb", 32'(sWeb), 32'd1);
    checkOutput("rdWmask", 32'(sWmask), 32'd0);
    checkOutput("rdDatHeld", wbs_dat_o, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("ctrlCount1", rd, 32'h0001_0001);

    applyStimulus(1'b1, 32'h3000_03FC, 32'hFFFF_FFFF, 4'hF, 8, rd, lat);
    applyStimulus(1'b1, 32'h3000_03FC, 32'h1122_3344, 4'b0101, 8, rd, lat);
    checkOutput("partWmask", 32'(sWmask), 32'h5);
    checkOutput("partAddr", 32'(sAddr), 32'd255);
    applyStimulus(1'b0, 32'h3000_03FC, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("partRead", rd, 32'hFF22_FF44);
    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("ctrlCount3", rd, 32'h0003_0001);

    applyStimulus(1'b1, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("holdWrLat", lat, 32'd1);
    checkOutput("holdAtAck", 32'(holdAtAck), 32'd0);
    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("ctrlHold0", rd, 32'h0003_0000);
    applyStimulus(1'b1, 32'h3000_0400, 32'hFFFF_FFFF, 4'b1110, 8, rd, lat);
    checkOutput("holdSelIgnored", 32'(core_hold), 32'd0);
    applyStimulus(1'b1, 32'h3000_0400, 32'h0000_0001, 4'b0001, 8, rd, lat);
    checkOutput("holdSet", 32'(core_hold), 32'd1);

    applyStimulus(1'b0, 32'h3000_0800, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("missData", rd, 32'h0);
    checkOutput("missLat", lat, 32'd1);
    checkOutput("missNoStrobe", strobes, 32'd0);
    applyStimulus(1'b1, 32'h3000_0804, 32'hFFFF_FFFF, 4'hF, 8, rd, lat);
    checkOutput("missWrLat", lat, 32'd1);
    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("missWrNoEffect", rd, 32'h0003_0001);

    applyStimulus(1'b0, 32'h3000_1000, 32'h0, 4'hF, 6, rd, lat);
    checkOutput("outsideNoAck", lat, 32'hFFFF_FFFF);

    // cyc dropped after edge N+1 of a write to word 7
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_001C; wdat = 32'hCAFE_F00D; sel = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    ackCount = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (wbs_ack_o) ackCount++;
    end
    checkOutput("abortNoAck", ackCount, 32'd0);
    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("abortCounted", rd, 32'h0004_0001);
    applyStimulus(1'b0, 32'h3000_001C, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("abortCommitted", rd, 32'hCAFE_F00D);

    // stb held high: second access accepted the cycle after ACK
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
    ackCount = 0; firstAck = -1; secondAck = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        ackCount++;
        if (firstAck < 0) firstAck = j; else secondAck = j;
        checkOutput("b2bData", wbs_dat_o, 32'hDEAD_BEEF);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    checkOutput("b2bAckCount", ackCount, 32'd2);
    checkOutput("b2bFirstAck", firstAck, 32'd4);
    checkOutput("b2bSecondAck", secondAck, 32'd9);

    // reset asserted while a write strobe is on the SRAM pins
    applyStimulus(1'b1, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0014; wdat = 32'h1234_5678; sel = 4'hF;
    @(negedge clk);
    checkOutput("preRstCsb", 32'(sram_csb0), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstCsb", 32'(sram_csb0), 32'd1);
    checkOutput("midRstDin", sram_din0, 32'd0);
    checkOutput("midRstAddr", 32'(sram_addr0), 32'd0);
    checkOutput("midRstHold", 32'(core_hold), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("postRstCtrl", rd, 32'h0000_0001);

    // write counter wrap, preloaded near the top
    @(negedge clk);
    force dut.wcnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.wcnt_q;
    applyStimulus(1'b1, 32'h3000_0024, 32'h0000_00AA, 4'hF, 8, rd, lat);
    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("wcntTop", rd, 32'hFFFF_0001);
    applyStimulus(1'b1, 32'h3000_0024, 32'h0000_00BB, 4'hF, 8, rd, lat);
    applyStimulus(1'b0, 32'h3000_0400, 32'h0, 4'hF, 8, rd, lat);
    checkOutput("wcntWrap", rd, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
